// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running counter stream: acquires lock on
// consecutive +1 steps, flags and counts slips, and tracks accepted-stream parity.
module counter_monitor #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 2,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             parity_out,
    output logic [WIDTH-1:0] expected
);
    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED, SLIP} state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);
    localparam logic [LW-1:0]    LOSS_V = LW'(LOSS_CNT);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] last, last_nxt, expected_nxt;
    logic [MW-1:0]    match_cnt, match_nxt;
    logic [LW-1:0]    miss_cnt, miss_nxt;
    logic [ERR_W-1:0] err_count_nxt;
    logic             parity_nxt, err_nxt, locked_nxt, match;

    // Wraps naturally at WIDTH bits, so all-ones -> zero counts as a good step.
    assign match = (cnt_in == last + ONE);

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        expected_nxt = expected;
        match_nxt    = match_cnt;
        miss_nxt     = miss_cnt;
        parity_nxt   = parity_out;
        err_nxt      = 1'b0;
        if (cnt_valid) begin
            last_nxt     = cnt_in;
            expected_nxt = cnt_in + ONE;
            case (state)
                UNLOCKED: begin
                    state_nxt = ACQUIRE;
                    match_nxt = '0;
                end
                ACQUIRE: begin
                    if (match) begin
                        match_nxt = match_cnt + MW'(1);
                        if (match_nxt == LOCK_V) begin
                            state_nxt  = LOCKED;
                            parity_nxt = cnt_in[0];
                            match_nxt  = '0;
                        end
                    end else begin
                        match_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        parity_nxt = ~parity_out;
                    end else begin
                        err_nxt   = 1'b1;
                        miss_nxt  = LW'(1);
                        state_nxt = SLIP;
                        if (miss_nxt == LOSS_V) begin
                            state_nxt = UNLOCKED;
                            miss_nxt  = '0;
                        end
                    end
                end
                SLIP: begin
                    if (match) begin
                        state_nxt  = LOCKED;
                        miss_nxt   = '0;
                        parity_nxt = ~parity_out;
                    end else begin
                        err_nxt  = 1'b1;
                        miss_nxt = miss_cnt + LW'(1);
                        if (miss_nxt == LOSS_V) begin
                            state_nxt = UNLOCKED;
                            miss_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = UNLOCKED;
            endcase
        end

        // clear wins over a same-cycle increment; the pulse itself is unaffected.
        err_count_nxt = err_count;
        if (clear)
            err_count_nxt = '0;
        else if (err_nxt && err_count != '1)
            err_count_nxt = err_count + ERR_W'(1);

        locked_nxt = (state_nxt == LOCKED) || (state_nxt == SLIP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            last       <= '0;
            expected   <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            parity_out <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            expected   <= expected_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            parity_out <= parity_nxt;
            err_pulse  <= err_nxt;
            err_count  <= err_count_nxt;
            locked     <= locked_nxt;
        end
    end
endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: vector table for the main stream plus
// hand sequences for async reset/relock, slip recovery and counter saturation.
module tb_counter_monitor;
    logic       clk = 1'b0;
    logic       rst_n, cnt_valid, clear;
    logic [7:0] cnt_in;
    logic       locked, err_pulse, parity_out;
    logic [7:0] err_count, expected;

    int checks = 0;
    int passed = 0;

    counter_monitor #(.WIDTH(8), .LOCK_CNT(2), .LOSS_CNT(3), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
        .parity_out(parity_out), .expected(expected)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       l;
        logic       e;
        logic [7:0] cnt;
        logic       p;
        logic [7:0] x;
    } vec_t;

    vec_t tbl[17];

    task automatic chk_out(input string tag, input logic l, input logic e,
                           input logic [7:0] c, input logic p, input logic [7:0] x);
        checks++;
        if (locked === l) passed++;
        else $display("FAIL %s locked: got %0b want %0b", tag, locked, l);
        checks++;
        if (err_pulse === e) passed++;
        else $display("FAIL %s err_pulse: got %0b want %0b", tag, err_pulse, e);
        checks++;
        if (err_count === c) passed++;
        else $display("FAIL %s err_count: got 0x%0h want 0x%0h", tag, err_count, c);
        checks++;
        if (parity_out === p) passed++;
        else $display("FAIL %s parity_out: got %0b want %0b", tag, parity_out, p);
        checks++;
        if (expected === x) passed++;
        else $display("FAIL %s expected: got 0x%0h want 0x%0h", tag, expected, x);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = d;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        //            v  data   clr  lock err cnt    par exp
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h11};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h12};
        tbl[2]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h13};
        tbl[3]  = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h13};
        tbl[4]  = '{1'b1, 8'h40, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 8'h41};
        tbl[5]  = '{1'b1, 8'h50, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 8'h51};
        tbl[6]  = '{1'b1, 8'h60, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 8'h61};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'h61};
        tbl[8]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'hF1};
        tbl[9]  = '{1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'hF2};
        tbl[10] = '{1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'hFD};
        tbl[11] = '{1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'hFE};
        tbl[12] = '{1'b1, 8'hFE, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'hFF};
        tbl[13] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'h00};
        tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'h01};
        tbl[15] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'h02};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'h02};

        rst_n = 1'b0; cnt_valid = 1'b0; clear = 1'b0; cnt_in = 8'h00;
        #12;
        chk_out("reset", 1'b0, 1'b0, 8'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk_out($sformatf("vec%0d", i), tbl[i].l, tbl[i].e, tbl[i].cnt, tbl[i].p, tbl[i].x);
        end

        // Asynchronous reset mid-lock, checked before any clock edge.
        @(negedge clk);
        #2;
        cnt_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 8'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h1E, 1'b0); chk_out("relock0", 1'b0, 1'b0, 8'd0, 1'b0, 8'h1F);
        step(1'b1, 8'h1F, 1'b0); chk_out("relock1", 1'b0, 1'b0, 8'd0, 1'b0, 8'h20);
        step(1'b1, 8'h20, 1'b0); chk_out("relock2", 1'b1, 1'b0, 8'd0, 1'b0, 8'h21);

        // Single slip then recovery: lock held throughout.
        step(1'b1, 8'h25, 1'b0); chk_out("slip_bad", 1'b1, 1'b1, 8'd1, 1'b0, 8'h26);
        step(1'b1, 8'h26, 1'b0); chk_out("slip_ok", 1'b1, 1'b0, 8'd1, 1'b1, 8'h27);

        // Alternate bad/good samples to drive err_count to saturation.
        v = 8'h26;
        for (int i = 0; i < 254; i++) begin
            v = v + 8'd2;
            step(1'b1, v, 1'b0);
            v = v + 8'd1;
            step(1'b1, v, 1'b0);
        end
        chk_out("sat_reach", 1'b1, 1'b0, 8'hFF, 1'b1, v + 8'd1);
        v = v + 8'd2;
        step(1'b1, v, 1'b0);
        chk_out("sat_hold", 1'b1, 1'b1, 8'hFF, 1'b1, v + 8'd1);
        v = v + 8'd2;
        step(1'b1, v, 1'b1);
        chk_out("clear_err", 1'b1, 1'b1, 8'd0, 1'b1, v + 8'd1);
        step(1'b0, 8'h00, 1'b0);
        chk_out("idle", 1'b1, 1'b0, 8'd0, 1'b1, v + 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
